// File: rtl/exe_stage_unit.sv
// exe_stage_unit: execute stage of a 5-stage ARM-style pipeline.
//   Computes the ALU result and the next NZCV flags from the ID-stage
//   operands, owns the status register and drives the EXE/MEM
//   pipeline register.
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   exe_cmd           ALU operation select
//   *_in              decoded control bits (load, store, write-back,
//                     branch, S bit)
//   val_rn, val2      ALU operands; st_val_in is the store data
//   dest_in           destination register index
//   pc_in, branch_imm branch target inputs (24-bit signed word offset)
//   freeze, flush     hold all state / squash the instruction in EX
//   alu_res, st_val, dest, mem_read, mem_write, wb_en
//                     registered EXE/MEM outputs
//   branch_taken, branch_addr
//                     combinational branch resolution
//   sr                status register {N,Z,C,V}
module exe_stage_unit #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        exe_cmd,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              wb_en_in,
    input  logic              b_in,
    input  logic              update_sr_in,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val2,
    input  logic [DATA_W-1:0] st_val_in,
    input  logic [REG_W-1:0]  dest_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [23:0]       branch_imm,
    input  logic              freeze,
    input  logic              flush,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] st_val,
    output logic [REG_W-1:0]  dest,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_en,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_addr,
    output logic [3:0]        sr
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam int         MSB     = DATA_W - 1;

    logic [DATA_W-1:0] alu_res_q, st_val_q;
    logic [REG_W-1:0]  dest_q;
    logic              mem_read_q, mem_write_q, wb_en_q;
    logic [3:0]        sr_q;

    logic [DATA_W-1:0] res_d;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   cin_ext;
    logic [DATA_W:0]   one_ext;
    logic              c_d, v_d;
    logic [3:0]        sr_d;

    // Carry-in comes from the registered flags, so ADC/SBC always see
    // the flags as they were before this instruction.
    assign cin_ext = {{DATA_W{1'b0}}, sr_q[1]};
    assign one_ext = {{DATA_W{1'b0}}, 1'b1};

    always_comb begin
        res_d = '0;
        sum   = '0;
        c_d   = sr_q[1];
        v_d   = sr_q[0];
        case (exe_cmd)
            CMD_MOV: res_d = val2;
            CMD_MVN: res_d = ~val2;
            CMD_ADD, CMD_ADC: begin
                sum   = {1'b0, val_rn} + {1'b0, val2}
                      + ((exe_cmd == CMD_ADC) ? cin_ext : '0);
                res_d = sum[MSB:0];
                c_d   = sum[DATA_W];
                v_d   = (val_rn[MSB] == val2[MSB]) && (res_d[MSB] != val_rn[MSB]);
            end
            CMD_SUB, CMD_SBC: begin
                // rn + ~val2 + 1 (SUB) or + Cin (SBC); the carry out is
                // the ARM "not borrow" convention directly.
                sum   = {1'b0, val_rn} + {1'b0, ~val2}
                      + ((exe_cmd == CMD_SUB) ? one_ext : cin_ext);
                res_d = sum[MSB:0];
                c_d   = sum[DATA_W];
                v_d   = (val_rn[MSB] != val2[MSB]) && (res_d[MSB] != val_rn[MSB]);
            end
            CMD_AND: res_d = val_rn & val2;
            CMD_ORR: res_d = val_rn | val2;
            CMD_EOR: res_d = val_rn ^ val2;
            default: res_d = '0;
        endcase
        sr_d = {res_d[MSB], (res_d == '0), c_d, v_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_res_q   <= '0;
            st_val_q    <= '0;
            dest_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            wb_en_q     <= 1'b0;
            sr_q        <= '0;
        end else if (flush) begin
            // Bubble: squashed instruction must not touch the flags.
            alu_res_q   <= '0;
            st_val_q    <= '0;
            dest_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            wb_en_q     <= 1'b0;
        end else if (!freeze) begin
            alu_res_q   <= res_d;
            st_val_q    <= st_val_in;
            dest_q      <= dest_in;
            mem_read_q  <= mem_read_in;
            mem_write_q <= mem_write_in;
            wb_en_q     <= wb_en_in;
            if (update_sr_in)
                sr_q <= sr_d;
        end
    end

    assign alu_res   = alu_res_q;
    assign st_val    = st_val_q;
    assign dest      = dest_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign wb_en     = wb_en_q;
    assign sr        = sr_q;

    // Word offset: sign-extend the 24-bit immediate and scale by 4.
    assign branch_taken = b_in & ~flush;
    assign branch_addr  = pc_in + {{(DATA_W-26){branch_imm[23]}}, branch_imm, 2'b00};

endmodule

// File: tb/tb_exe_stage_unit.sv
module tb_exe_stage_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  exe_cmd;
    logic        mem_read_in, mem_write_in, wb_en_in, b_in, update_sr_in;
    logic [31:0] val_rn, val2, st_val_in, pc_in;
    logic [3:0]  dest_in;
    logic [23:0] branch_imm;
    logic        freeze, flush;
    logic [31:0] alu_res, st_val, branch_addr;
    logic [3:0]  dest, sr;
    logic        mem_read, mem_write, wb_en, branch_taken;

    exe_stage_unit #(.DATA_W(32), .REG_W(4)) dut (
        .clk(clk), .rst(rst), .exe_cmd(exe_cmd),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .wb_en_in(wb_en_in), .b_in(b_in), .update_sr_in(update_sr_in),
        .val_rn(val_rn), .val2(val2), .st_val_in(st_val_in),
        .dest_in(dest_in), .pc_in(pc_in), .branch_imm(branch_imm),
        .freeze(freeze), .flush(flush),
        .alu_res(alu_res), .st_val(st_val), .dest(dest),
        .mem_read(mem_read), .mem_write(mem_write), .wb_en(wb_en),
        .branch_taken(branch_taken), .branch_addr(branch_addr), .sr(sr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] st;
        logic [3:0]  dst;
        logic        mr, mw, wb;
        logic [3:0]  sr;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic drv(input logic [3:0] cmd, input logic mr, mw, wb, s,
                       input logic [31:0] rn, v2, st, input logic [3:0] dst,
                       input logic frz, fl);
        exe_cmd = cmd; mem_read_in = mr; mem_write_in = mw; wb_en_in = wb;
        update_sr_in = s; val_rn = rn; val2 = v2; st_val_in = st;
        dest_in = dst; freeze = frz; flush = fl;
        b_in = 1'b0; pc_in = '0; branch_imm = '0;
    endtask

    task automatic push(input logic [31:0] res, st, input logic [3:0] dst,
                        input logic mr, mw, wb, input logic [3:0] s, input string nm);
        exp_t e;
        e.res = res; e.st = st; e.dst = dst; e.mr = mr; e.mw = mw; e.wb = wb;
        e.sr = s; e.nm = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: the pipeline register presents a new value every edge;
    // compare it against the oldest outstanding expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.nm, ".alu_res"}, alu_res, e.res);
                chk({e.nm, ".st_val"}, st_val, e.st);
                chk({e.nm, ".dest"}, {28'd0, dest}, {28'd0, e.dst});
                chk({e.nm, ".ctl"}, {29'd0, mem_read, mem_write, wb_en}, {29'd0, e.mr, e.mw, e.wb});
                chk({e.nm, ".sr"}, {28'd0, sr}, {28'd0, e.sr});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [3:0] MOV = 4'b0001, ADD = 4'b0010, ADC = 4'b0011,
                           SUB = 4'b0100, SBC = 4'b0101, AND_ = 4'b0110,
                           ORR = 4'b0111, EOR = 4'b1000, MVN = 4'b1001,
                           NOP = 4'b0000;

    initial begin
        rst = 1'b1;
        drv(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("reset.alu_res", alu_res, 32'h0);
        chk("reset.ctl", {28'd0, mem_read, mem_write, wb_en, branch_taken}, 32'h0);
        chk("reset.sr", {28'd0, sr}, 32'h0);
        @(negedge clk); rst = 1'b0;

        // Signed overflow on ADD
        drv(ADD, 0, 0, 1, 1, 32'h7FFF_FFFF, 32'h1, 32'hAA, 4'd3, 0, 0);
        push(32'h8000_0000, 32'hAA, 4'd3, 0, 0, 1, 4'b1001, "add_ovf");
        @(negedge clk);
        drv(SUB, 0, 0, 1, 1, 32'd5, 32'd5, 32'h0, 4'd4, 0, 0);
        push(32'h0, 32'h0, 4'd4, 0, 0, 1, 4'b0110, "sub_zero");
        @(negedge clk);
        // ADC uses C=1 from the SUB; S=0 keeps flags
        drv(ADC, 0, 0, 1, 0, 32'd1, 32'd1, 32'h0, 4'd5, 0, 0);
        push(32'd3, 32'h0, 4'd5, 0, 0, 1, 4'b0110, "adc_cin");
        @(negedge clk);
        drv(ADD, 0, 0, 1, 1, 32'd1, 32'd1, 32'h0, 4'd5, 0, 0);
        push(32'd2, 32'h0, 4'd5, 0, 0, 1, 4'b0000, "add_clrc");
        @(negedge clk);
        drv(SBC, 0, 0, 1, 1, 32'd0, 32'd0, 32'h0, 4'd6, 0, 0);
        push(32'hFFFF_FFFF, 32'h0, 4'd6, 0, 0, 1, 4'b1000, "sbc_c0");
        @(negedge clk);
        // Store: address generation, flags untouched
        drv(ADD, 0, 1, 0, 0, 32'h100, 32'h8, 32'hDEAD_BEEF, 4'd7, 0, 0);
        push(32'h108, 32'hDEAD_BEEF, 4'd7, 0, 1, 0, 4'b1000, "store");
        @(negedge clk);
        drv(SUB, 0, 0, 1, 1, 32'h8000_0000, 32'h1, 32'h0, 4'd1, 0, 0);
        push(32'h7FFF_FFFF, 32'h0, 4'd1, 0, 0, 1, 4'b0011, "sub_ovf");
        @(negedge clk);
        drv(MVN, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0, 4'd1, 0, 0);
        push(32'hFFFF_FFFF, 32'h0, 4'd1, 0, 0, 1, 4'b1011, "mvn");
        @(negedge clk);
        drv(AND_, 0, 0, 1, 1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0, 4'd2, 0, 0);
        push(32'h0, 32'h0, 4'd2, 0, 0, 1, 4'b0111, "and");
        @(negedge clk);
        drv(ORR, 1, 0, 1, 0, 32'hF000_0000, 32'h0000_000F, 32'h0, 4'd2, 0, 0);
        push(32'hF000_000F, 32'h0, 4'd2, 1, 0, 1, 4'b0111, "orr_load");
        @(negedge clk);
        drv(EOR, 0, 0, 1, 1, 32'hFFFF_0000, 32'hFF00_FF00, 32'h0, 4'd2, 0, 0);
        push(32'h00FF_FF00, 32'h0, 4'd2, 0, 0, 1, 4'b0011, "eor");
        @(negedge clk);
        drv(NOP, 0, 0, 1, 1, 32'h1234, 32'h5678, 32'h0, 4'd6, 0, 0);
        push(32'h0, 32'h0, 4'd6, 0, 0, 1, 4'b0111, "nop_flags");

        // Freeze for three cycles with changing inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drv(ADD, 1, 1, 0, 1, 32'h10 + i, 32'h20, 32'h99, 4'd9, 1, 0);
            push(32'h0, 32'h0, 4'd6, 0, 0, 1, 4'b0111, "freeze");
        end
        @(negedge clk);
        drv(ADD, 1, 1, 1, 1, 32'd1, 32'd1, 32'h77, 4'd9, 0, 1);
        push(32'h0, 32'h0, 4'd0, 0, 0, 0, 4'b0111, "flush");
        @(negedge clk);
        drv(MOV, 0, 0, 1, 0, 32'h0, 32'h55, 32'h11, 4'd9, 0, 0);
        push(32'h55, 32'h11, 4'd9, 0, 0, 1, 4'b0111, "mov");
        @(negedge clk);
        drv(ADD, 1, 1, 1, 1, 32'd1, 32'd1, 32'h77, 4'd9, 1, 1);
        push(32'h0, 32'h0, 4'd0, 0, 0, 0, 4'b0111, "flush_freeze");

        // Branches: combinational target and taken
        @(negedge clk);
        drv(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        b_in = 1'b1; pc_in = 32'h40; branch_imm = 24'hFF_FFFE;
        push(32'h0, 32'h0, 4'd0, 0, 0, 0, 4'b0111, "br_back");
        #1;
        chk("br_back.taken", {31'd0, branch_taken}, 32'd1);
        chk("br_back.addr", branch_addr, 32'h38);
        @(negedge clk);
        drv(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        b_in = 1'b1; pc_in = 32'h100; branch_imm = 24'h00_0010;
        push(32'h0, 32'h0, 4'd0, 0, 0, 0, 4'b0111, "br_fwd");
        #1;
        chk("br_fwd.addr", branch_addr, 32'h140);
        @(negedge clk);
        drv(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        b_in = 1'b1; pc_in = 32'hFFFF_FFFC; branch_imm = 24'h00_0001;
        push(32'h0, 32'h0, 4'd0, 0, 0, 0, 4'b0111, "br_flush");
        #1;
        chk("br_flush.taken", {31'd0, branch_taken}, 32'd0);
        chk("br_wrap.addr", branch_addr, 32'h0);

        // Load a value, then assert reset mid-cycle
        @(negedge clk);
        drv(SUB, 1, 0, 1, 1, 32'd5, 32'd2, 32'h33, 4'd8, 0, 0);
        push(32'd3, 32'h33, 4'd8, 1, 0, 1, 4'b0010, "pre_rst");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst.alu_res", alu_res, 32'h0);
        chk("midrst.st_val", st_val, 32'h0);
        chk("midrst.ctl", {27'd0, dest, mem_read, mem_write, wb_en} & 32'h7F, 32'h0);
        chk("midrst.sr", {28'd0, sr}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        // Carry was cleared by reset, so ADC adds no carry
        drv(ADC, 0, 0, 1, 1, 32'd1, 32'd1, 32'h0, 4'd3, 0, 0);
        push(32'd2, 32'h0, 4'd3, 0, 0, 1, 4'b0000, "adc_post_rst");

        begin
            int budget;
            budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            n_cmp++;
            if (exp_q.size() > 0) begin
                n_err++;
                $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exe_stage_unit.md
Name: exe_stage_unit

Overview:
- Execute stage of the 5-stage ARM pipeline; consumes the decoder's execute command and control bits (mem_read, mem_write, WB_enable, B, Update_SR) plus ID-stage operands.
- Performs the ALU operation, owns the NZCV status register, registers results into the EXE/MEM pipeline register.
- Latency 1 cycle, subject to freeze and flush control.

Parameters:
- DATA_W, 32, operand/result width
- REG_W, 4, destination register index width

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-high reset
- exe_cmd  input  4  execute command from the decoder
- mem_read_in  input  1  load indicator
- mem_write_in  input  1  store indicator
- wb_en_in  input  1  register write-back enable
- b_in  input  1  branch indicator
- update_sr_in  input  1  S bit: update NZCV
- val_rn  input  DATA_W  first operand
- val2  input  DATA_W  second operand (shifter output)
- st_val_in  input  DATA_W  store data (Rd value)
- dest_in  input  REG_W  destination register
- pc_in  input  DATA_W  PC of instruction
- branch_imm  input  24  signed word offset
- freeze  input  1  hold all state
- flush  input  1  squash current instruction
- alu_res  output  DATA_W  registered ALU result / memory address
- st_val  output  DATA_W  registered store data
- dest  output  REG_W  registered destination
- mem_read  output  1  registered
- mem_write  output  1  registered
- wb_en  output  1  registered
- branch_taken  output  1  combinational, = b_in & ~flush
- branch_addr  output  DATA_W  combinational, pc_in + (sign-extended branch_imm << 2)
- sr  output  4  status register {N,Z,C,V}

Behaviour:
- Reset: all registered outputs and sr = 0, effective immediately (async); first update on first rising edge after rst deasserts.
- ALU, combinational on current inputs, Cin = sr[1]:
  - 0001 MOV: val2.
  - 1001 MVN: ~val2.
  - 0010 ADD: rn+val2.
  - 0011 ADC: rn+val2+Cin.
  - 0100 SUB: rn-val2.
  - 0101 SBC: rn-val2-(1-Cin).
  - 0110 AND, 0111 ORR, 1000 EOR.
  - 0000 / any other: result 0, flags N,Z from 0, C,V unchanged.
- Arithmetic is DATA_W+1 wide:
  - Add: C = bit DATA_W.
  - Subtract: C = NOT borrow (1 when no borrow).
  - V = signed overflow: operands same sign and result sign differs (add); operands differ and result sign differs from rn (sub).
- N = result[MSB]; Z = (result == 0).
- Logical ops and MOV/MVN leave C,V unchanged.
- Memory instructions arrive with exe_cmd 0010, so alu_res = rn + val2 = effective address.
- Each rising edge, priority order (highest first):
  1. flush: pipeline register loads a bubble (mem_read, mem_write, wb_en = 0; data fields 0). sr unchanged.
  2. freeze (flush=0): all registers and sr hold.
  3. Normal: pipeline register captures result and control bits. If update_sr_in = 1, sr loads the new NZCV, else holds.
- sr is read (Cin) before it is written in the same cycle, so ADC/SBC use the prior flags. Back-to-back flag-setting instructions chain correctly.
- branch_taken / branch_addr are combinational:
  - asserted in the cycle the branch is in EX;
  - suppressed by flush;
  - unaffected by freeze (the hazard unit guarantees no freeze on branches).
- Address arithmetic wraps modulo 2^DATA_W.

Test Plan:
1. ADD, S=1, rn=0x7FFFFFFF, val2=1 -> next edge alu_res=0x80000000, sr=4'b1001 (N,V), wb_en=1.
2. SUB, S=1, rn=5, val2=5 -> alu_res=0, sr=4'b0110 (Z,C); then ADC, S=0, rn=1, val2=1 -> alu_res=3, sr still 0110.
3. SBC, S=1, C=0, rn=0, val2=0 -> alu_res=0xFFFFFFFF, sr=4'b1000.
4. Memory store: exe_cmd=0010, mem_write_in=1, rn=0x100, val2=8 -> alu_res=0x108, mem_write=1, wb_en=0, sr unchanged.
5. Control priority: freeze=1 for 3 cycles with changing inputs -> outputs and sr frozen. flush=1 with ADD/S=1 -> mem_read, mem_write, wb_en = 0, sr unchanged. flush and freeze together -> bubble.
6. Branch and reset: b_in=1, pc_in=0x40, imm=0xFFFFFE -> branch_taken=1, branch_addr=0x38. Assert rst mid-cycle after a load -> all outputs 0 before the next edge.
